// File: rtl/rx_data_indication.sv
// MII receive data indication: strips preamble/SFD, assembles nibble pairs (low first)
// into octets, and reports frame validity, octet count and end-of-frame status.
module rx_data_indication #(
    parameter int MIN_PREAMBLE    = 1,
    parameter int MAX_FRAME_BYTES = 1522
) (
    input  logic        clk,
    input  logic        reset_L,
    input  logic        rx_dv,
    input  logic [3:0]  rxd,
    input  logic        rx_er,
    output logic [7:0]  pls_data_indication,
    output logic        pls_data_ind_valid,
    output logic        pls_data_valid_indication,
    output logic        frame_end,
    output logic        frame_error,
    output logic [15:0] byte_count
);

    localparam logic [3:0]  PRE_NIB   = 4'h5;
    localparam logic [3:0]  SFD_NIB   = 4'hD;
    localparam logic [3:0]  MIN_PRE_C = 4'(MIN_PREAMBLE);
    localparam logic [15:0] MAX_BYTES = 16'(MAX_FRAME_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_LOW_NIB,
        S_HIGH_NIB,
        S_DROP
    } state_t;

    state_t      r_state;
    logic [3:0]  r_pre_cnt;
    logic [3:0]  r_low_nib;
    logic        r_err;
    logic [7:0]  r_data;
    logic        r_data_vld;
    logic        r_valid_ind;
    logic        r_frame_end;
    logic        r_frame_error;
    logic [15:0] r_byte_count;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_state       <= S_IDLE;
            r_pre_cnt     <= 4'd0;
            r_low_nib     <= 4'd0;
            r_err         <= 1'b0;
            r_data        <= 8'd0;
            r_data_vld    <= 1'b0;
            r_valid_ind   <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_error <= 1'b0;
            r_byte_count  <= 16'd0;
        end else begin
            r_data_vld    <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rx_dv) begin
                        if (rxd == PRE_NIB) begin
                            r_state   <= S_PREAMBLE;
                            r_pre_cnt <= 4'd1;
                        end else begin
                            r_state <= S_DROP;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (!rx_dv) begin
                        r_state <= S_IDLE;
                    end else if (rxd == PRE_NIB) begin
                        if (r_pre_cnt != 4'hF) r_pre_cnt <= r_pre_cnt + 4'd1;
                    end else if (rxd == SFD_NIB && r_pre_cnt >= MIN_PRE_C) begin
                        r_state      <= S_LOW_NIB;
                        r_valid_ind  <= 1'b1;
                        r_byte_count <= 16'd0;
                        r_err        <= 1'b0;
                    end else begin
                        r_state <= S_DROP;
                    end
                end
                S_LOW_NIB: begin
                    if (rx_dv) begin
                        r_low_nib <= rxd;
                        r_state   <= S_HIGH_NIB;
                        if (rx_er) r_err <= 1'b1;
                    end else begin
                        r_state       <= S_IDLE;
                        r_frame_end   <= 1'b1;
                        r_frame_error <= r_err;
                        r_valid_ind   <= 1'b0;
                    end
                end
                S_HIGH_NIB: begin
                    if (rx_dv) begin
                        r_state <= S_LOW_NIB;
                        // Octets past the frame limit are discarded but still mark the frame bad.
                        if (r_byte_count < MAX_BYTES) begin
                            r_data       <= {rxd, r_low_nib};
                            r_data_vld   <= 1'b1;
                            r_byte_count <= r_byte_count + 16'd1;
                        end
                        if (rx_er || r_byte_count >= MAX_BYTES) r_err <= 1'b1;
                    end else begin
                        // Odd nibble count: the pending low nibble is dropped.
                        r_state       <= S_IDLE;
                        r_frame_end   <= 1'b1;
                        r_frame_error <= 1'b1;
                        r_valid_ind   <= 1'b0;
                    end
                end
                S_DROP: begin
                    if (!rx_dv) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pls_data_indication       = r_data;
    assign pls_data_ind_valid        = r_data_vld;
    assign pls_data_valid_indication = r_valid_ind;
    assign frame_end                 = r_frame_end;
    assign frame_error               = r_frame_error;
    assign byte_count                = r_byte_count;

endmodule

// File: tb/tb_rx_data_indication.sv
// Bench for rx_data_indication: two instances (default and 4-byte frame limit) share a
// per-cycle stimulus table; a frame-level model predicts every output for every cycle.
module tb_rx_data_indication;

    localparam int NMAX  = 8000;
    localparam int MAXS  = 4;
    localparam int MAXB  = 1522;
    localparam int MINP  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_L;
    logic       rx_dv;
    logic [3:0] rxd;
    logic       rx_er;

    logic [7:0]  dat_a, dat_b;
    logic        vld_a, vld_b, vi_a, vi_b, fe_a, fe_b, fer_a, fer_b;
    logic [15:0] bc_a, bc_b;

    rx_data_indication #(.MIN_PREAMBLE(MINP), .MAX_FRAME_BYTES(MAXB)) dut_a (
        .clk(clk), .reset_L(reset_L), .rx_dv(rx_dv), .rxd(rxd), .rx_er(rx_er),
        .pls_data_indication(dat_a), .pls_data_ind_valid(vld_a),
        .pls_data_valid_indication(vi_a), .frame_end(fe_a), .frame_error(fer_a),
        .byte_count(bc_a)
    );

    rx_data_indication #(.MIN_PREAMBLE(MINP), .MAX_FRAME_BYTES(MAXS)) dut_b (
        .clk(clk), .reset_L(reset_L), .rx_dv(rx_dv), .rxd(rxd), .rx_er(rx_er),
        .pls_data_indication(dat_b), .pls_data_ind_valid(vld_b),
        .pls_data_valid_indication(vi_b), .frame_end(fe_b), .frame_error(fer_b),
        .byte_count(bc_b)
    );

    // Stimulus table, one entry per clock edge
    logic       s_rst [NMAX];
    logic       s_dv  [NMAX];
    logic [3:0] s_d   [NMAX];
    logic       s_er  [NMAX];
    int         n;

    // Model expectations and observations, index 0 = dut_a, 1 = dut_b
    logic        e_dv  [2][NMAX];
    logic [7:0]  e_dat [2][NMAX];
    logic        e_vi  [2][NMAX];
    logic        e_fe  [2][NMAX];
    logic        e_fer [2][NMAX];
    logic [15:0] e_bc  [2][NMAX];
    logic        o_dv  [2][NMAX];
    logic [7:0]  o_dat [2][NMAX];
    logic        o_vi  [2][NMAX];
    logic        o_fe  [2][NMAX];
    logic        o_fer [2][NMAX];
    logic [15:0] o_bc  [2][NMAX];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input int c, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
        end
    endtask

    task automatic push(input logic r, input logic dv, input logic [3:0] d, input logic er);
        if (n < NMAX) begin
            s_rst[n] = r; s_dv[n] = dv; s_d[n] = d; s_er[n] = er;
            n++;
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) push(1'b1, 1'b0, 4'($urandom), 1'($urandom_range(0, 1)));
    endtask

    task automatic set_quiet(input int k, input int c);
        e_dv[k][c] = 1'b0; e_vi[k][c] = 1'b0; e_fe[k][c] = 1'b0; e_fer[k][c] = 1'b0;
    endtask

    // Frame-level model: each maximal run of rx_dv=1 edges outside reset is one burst.
    task automatic build_model(input int k, input int mx);
        int c, s, e, p, sfd, nb, pc;
        logic acc, err;
        logic [15:0] bc;
        logic [7:0] last;
        bc = 16'd0; last = 8'd0; c = 0;
        while (c < n) begin
            if (!s_rst[c]) begin
                set_quiet(k, c);
                bc = 16'd0; last = 8'd0;
                e_bc[k][c] = bc; e_dat[k][c] = last;
                c++;
            end else if (!s_dv[c]) begin
                set_quiet(k, c);
                e_bc[k][c] = bc; e_dat[k][c] = last;
                c++;
            end else begin
                s = c; e = c;
                while (e < n && s_rst[e] && s_dv[e]) e++;
                p = 0;
                while (s + p < e && s_d[s+p] == 4'h5) p++;
                sfd = s + p;
                pc  = (p > 15) ? 15 : p;
                acc = (p >= 1) && (sfd < e) && (s_d[sfd] == 4'hD) && (pc >= MINP);
                err = 1'b0; nb = 0;
                for (int i = s; i < e; i++) begin
                    set_quiet(k, i);
                    if (acc && i >= sfd) begin
                        e_vi[k][i] = 1'b1;
                        if (i == sfd) begin
                            bc = 16'd0;
                        end else begin
                            if (s_er[i]) err = 1'b1;
                            if (((i - sfd) % 2) == 0) begin
                                if (nb < mx) begin
                                    last = {s_d[i], s_d[i-1]};
                                    e_dv[k][i] = 1'b1;
                                    bc = bc + 16'd1;
                                end else begin
                                    err = 1'b1;
                                end
                                nb++;
                            end
                        end
                    end
                    e_bc[k][i] = bc; e_dat[k][i] = last;
                end
                c = e;
                if (e < n && s_rst[e]) begin
                    set_quiet(k, e);
                    e_bc[k][e] = bc; e_dat[k][e] = last;
                    if (acc) begin
                        e_fe[k][e]  = 1'b1;
                        e_fer[k][e] = err || (((e - 1 - sfd) % 2) == 1);
                    end
                    c = e + 1;
                end
            end
        end
    endtask

    int t2, t3, t4, t5, t5g, t6, tr;

    initial begin
        int cnt, npre, nd;
        reset_L = 1'b0; rx_dv = 1'b0; rxd = 4'h0; rx_er = 1'b0;
        n = 0;

        // Reset held with a preamble already on the wire, then a long-preamble frame
        for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 4'h5, 1'b0);
        for (int i = 0; i < 15; i++) push(1'b1, 1'b1, 4'h5, 1'b0);
        t2 = n; push(1'b1, 1'b1, 4'hD, 1'b0);
        push(1'b1, 1'b1, 4'h3, 1'b0); push(1'b1, 1'b1, 4'h2, 1'b0);
        push(1'b1, 1'b1, 4'h1, 1'b0); push(1'b1, 1'b1, 4'h0, 1'b0);
        push(1'b1, 1'b0, 4'h0, 1'b0); idle(3);

        // Same frame with rx_er on one data nibble
        for (int i = 0; i < 15; i++) push(1'b1, 1'b1, 4'h5, 1'b0);
        t3 = n; push(1'b1, 1'b1, 4'hD, 1'b0);
        push(1'b1, 1'b1, 4'h3, 1'b0); push(1'b1, 1'b1, 4'h2, 1'b1);
        push(1'b1, 1'b1, 4'h1, 1'b0); push(1'b1, 1'b1, 4'h0, 1'b0);
        push(1'b1, 1'b0, 4'h0, 1'b0); idle(3);

        // Odd nibble count
        push(1'b1, 1'b1, 4'h5, 1'b0); push(1'b1, 1'b1, 4'h5, 1'b0);
        t4 = n; push(1'b1, 1'b1, 4'hD, 1'b0);
        push(1'b1, 1'b1, 4'hA, 1'b0); push(1'b1, 1'b1, 4'hB, 1'b0); push(1'b1, 1'b1, 4'hC, 1'b0);
        push(1'b1, 1'b0, 4'h0, 1'b0); idle(3);

        // Burst starting with a non-preamble nibble is dropped whole
        t5 = n; push(1'b1, 1'b1, 4'h7, 1'b0);
        push(1'b1, 1'b1, 4'h5, 1'b0); push(1'b1, 1'b1, 4'h5, 1'b0); push(1'b1, 1'b1, 4'hD, 1'b0);
        push(1'b1, 1'b1, 4'h1, 1'b0); push(1'b1, 1'b1, 4'h2, 1'b0);
        push(1'b1, 1'b1, 4'h3, 1'b0); push(1'b1, 1'b1, 4'h4, 1'b0);
        push(1'b1, 1'b0, 4'h0, 1'b0); idle(2);
        push(1'b1, 1'b1, 4'h5, 1'b0); push(1'b1, 1'b1, 4'h5, 1'b0);
        t5g = n; push(1'b1, 1'b1, 4'hD, 1'b0);
        push(1'b1, 1'b1, 4'h4, 1'b0); push(1'b1, 1'b1, 4'h3, 1'b0);
        push(1'b1, 1'b0, 4'h0, 1'b0); idle(3);

        // Six-byte frame: 0x10,0x32,0x54,0x76,0x98,0xBA
        push(1'b1, 1'b1, 4'h5, 1'b0); push(1'b1, 1'b1, 4'h5, 1'b0);
        t6 = n; push(1'b1, 1'b1, 4'hD, 1'b0);
        for (int i = 0; i < 12; i++) push(1'b1, 1'b1, 4'(i), 1'b0);
        push(1'b1, 1'b0, 4'h0, 1'b0); idle(3);

        // Reset in the middle of a frame, tail of the burst continues, then a clean frame
        push(1'b1, 1'b1, 4'h5, 1'b0); push(1'b1, 1'b1, 4'h5, 1'b0);
        tr = n; push(1'b1, 1'b1, 4'hD, 1'b0);
        push(1'b1, 1'b1, 4'h1, 1'b0); push(1'b1, 1'b1, 4'h2, 1'b0); push(1'b1, 1'b1, 4'h3, 1'b0);
        push(1'b0, 1'b1, 4'h4, 1'b0); push(1'b0, 1'b1, 4'h4, 1'b0);
        push(1'b1, 1'b1, 4'h5, 1'b0); push(1'b1, 1'b1, 4'h6, 1'b0);
        push(1'b1, 1'b0, 4'h0, 1'b0); idle(2);
        push(1'b1, 1'b1, 4'h5, 1'b0); push(1'b1, 1'b1, 4'hD, 1'b0);
        push(1'b1, 1'b1, 4'hE, 1'b0); push(1'b1, 1'b1, 4'hF, 1'b0);
        push(1'b1, 1'b0, 4'h0, 1'b0); idle(3);

        // Randomized bursts
        for (int f = 0; f < 200 && n < NMAX - 80; f++) begin
            idle($urandom_range(1, 4));
            npre = $urandom_range(0, 17);
            if (npre == 0) push(1'b1, 1'b1, 4'($urandom), 1'b0);
            for (int i = 0; i < npre; i++) push(1'b1, 1'b1, 4'h5, 1'($urandom_range(0, 7) == 0));
            push(1'b1, 1'b1, ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hD, 1'b0);
            nd = $urandom_range(0, 20);
            for (int i = 0; i < nd; i++) begin
                if ($urandom_range(0, 60) == 0) push(1'b0, 1'b1, 4'($urandom), 1'b0);
                else push(1'b1, 1'b1, 4'($urandom), 1'($urandom_range(0, 15) == 0));
            end
            push(1'b1, 1'b0, 4'($urandom), 1'($urandom_range(0, 3) == 0));
        end
        idle(3);

        build_model(0, MAXB);
        build_model(1, MAXS);

        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            reset_L = s_rst[c]; rx_dv = s_dv[c]; rxd = s_d[c]; rx_er = s_er[c];
            @(posedge clk);
            #1;
            o_dv[0][c] = vld_a; o_dat[0][c] = dat_a; o_vi[0][c] = vi_a;
            o_fe[0][c] = fe_a;  o_fer[0][c] = fer_a; o_bc[0][c] = bc_a;
            o_dv[1][c] = vld_b; o_dat[1][c] = dat_b; o_vi[1][c] = vi_b;
            o_fe[1][c] = fe_b;  o_fer[1][c] = fer_b; o_bc[1][c] = bc_b;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("dut%0d.ind_valid", k), c, 16'(o_dv[k][c]), 16'(e_dv[k][c]));
                if (e_dv[k][c] || !s_rst[c])
                    chk($sformatf("dut%0d.data", k), c, 16'(o_dat[k][c]), 16'(e_dat[k][c]));
                chk($sformatf("dut%0d.valid_ind", k), c, 16'(o_vi[k][c]), 16'(e_vi[k][c]));
                chk($sformatf("dut%0d.frame_end", k), c, 16'(o_fe[k][c]), 16'(e_fe[k][c]));
                chk($sformatf("dut%0d.frame_error", k), c, 16'(o_fer[k][c]), 16'(e_fer[k][c]));
                chk($sformatf("dut%0d.byte_count", k), c, o_bc[k][c], e_bc[k][c]);
            end
        end

        // Hand-computed expectations for the directed frames
        chk("rst_all_zero", 2, {o_bc[0][2][7:0], o_dat[0][2]} | 16'({o_dv[0][2], o_vi[0][2], o_fe[0][2]}), 16'h0);
        chk("t2_byte0", t2 + 2, {7'd0, o_dv[0][t2+2], o_dat[0][t2+2]}, 16'h0123);
        chk("t2_byte1", t2 + 4, {7'd0, o_dv[0][t2+4], o_dat[0][t2+4]}, 16'h0101);
        chk("t2_model_byte0", t2 + 2, 16'(e_dat[0][t2+2]), 16'h0023);
        cnt = 0;
        for (int i = t2 - 1; i <= t2 + 6; i++) cnt += int'(o_vi[0][i]);
        chk("t2_valid_ind_len", t2, 16'(cnt), 16'd5);
        chk("t2_end", t2 + 5, {6'd0, o_fe[0][t2+5], o_fer[0][t2+5], o_bc[0][t2+5][7:0]}, 16'h0202);
        chk("t2_model_end", t2 + 5, 16'({e_fe[0][t2+5], e_fer[0][t2+5]}), 16'h2);
        chk("t3_bytes", t3 + 4, {o_dat[0][t3+2], o_dat[0][t3+4]}, 16'h2301);
        chk("t3_end", t3 + 5, 16'({o_fe[0][t3+5], o_fer[0][t3+5]}), 16'h3);
        chk("t4_byte", t4 + 2, {7'd0, o_dv[0][t4+2], o_dat[0][t4+2]}, 16'h01BA);
        chk("t4_end", t4 + 4, {6'd0, o_fe[0][t4+4], o_fer[0][t4+4], o_bc[0][t4+4][7:0]}, 16'h0301);
        cnt = 0;
        for (int i = t5; i <= t5 + 10; i++) cnt += int'(o_dv[0][i]) + int'(o_fe[0][i]) + int'(o_vi[0][i]);
        chk("t5_drop_silent", t5, 16'(cnt), 16'd0);
        chk("t5_next_good", t5g + 2, {7'd0, o_dv[0][t5g+2], o_dat[0][t5g+2]}, 16'h0134);
        chk("t6_small_last", t6 + 8, {7'd0, o_dv[1][t6+8], o_dat[1][t6+8]}, 16'h0176);
        chk("t6_small_drop", t6 + 10, 16'(o_dv[1][t6+10]), 16'h0);
        chk("t6_small_end", t6 + 13, {6'd0, o_fe[1][t6+13], o_fer[1][t6+13], o_bc[1][t6+13][7:0]}, 16'h0304);
        chk("t6_big_end", t6 + 13, {6'd0, o_fe[0][t6+13], o_fer[0][t6+13], o_bc[0][t6+13][7:0]}, 16'h0206);
        chk("t6_big_last", t6 + 12, 16'(o_dat[0][t6+12]), 16'h00BA);
        cnt = 0;
        for (int i = tr; i <= tr + 10; i++) cnt += int'(o_fe[0][i]);
        chk("rst_mid_no_end", tr, 16'(cnt), 16'd0);
        chk("rst_mid_cleared", tr + 4, o_bc[0][tr+4], 16'd0);
        chk("rst_next_byte", tr + 14, {7'd0, o_dv[0][tr+14], o_dat[0][tr+14]}, 16'h01FE);
        chk("rst_next_end", tr + 15, {6'd0, o_fe[0][tr+15], o_fer[0][tr+15], o_bc[0][tr+15][7:0]}, 16'h0201);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
